// File: rtl/bp_be_dcache_pkt_arbiter.sv
// bp_be_dcache_pkt_arbiter
//
// Merges the LCE tag_mem, data_mem and stat_mem packet streams into one
// registered packet stream. A one-entry output register presents the winner
// of a round-robin arbitration between the three sources. When the consumer
// takes the registered packet, a new one can be loaded in the same cycle, so
// a steady stream of one packet per cycle needs no bubbles.
//
// Ports
//   clk_i, reset_i                   clock, synchronous active-high reset
//   tag_mem_pkt_i / _v_i / _yumi_o   tag source: payload, valid, accept
//   data_mem_pkt_i / _v_i / _yumi_o  data source: payload, valid, accept
//   stat_mem_pkt_i / _v_i / _yumi_o  stat source: payload, valid, accept
//   freeze_i                         blocks new grants while high
//   pkt_o                            registered payload, zero-extended
//   pkt_type_o                       registered source: 0 tag, 1 data, 2 stat
//   pkt_v_o                          pkt_o / pkt_type_o are valid
//   pkt_yumi_i                       consumer takes pkt_o this cycle
module bp_be_dcache_pkt_arbiter #(
    parameter int tag_pkt_width_p  = 32,
    parameter int data_pkt_width_p = 600,
    parameter int stat_pkt_width_p = 16,
    localparam int td_width_lp  = (tag_pkt_width_p > data_pkt_width_p)
                                  ? tag_pkt_width_p : data_pkt_width_p,
    localparam int pkt_width_lp = (td_width_lp > stat_pkt_width_p)
                                  ? td_width_lp : stat_pkt_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [tag_pkt_width_p-1:0]  tag_mem_pkt_i,
    input  logic                        tag_mem_pkt_v_i,
    output logic                        tag_mem_pkt_yumi_o,

    input  logic [data_pkt_width_p-1:0] data_mem_pkt_i,
    input  logic                        data_mem_pkt_v_i,
    output logic                        data_mem_pkt_yumi_o,

    input  logic [stat_pkt_width_p-1:0] stat_mem_pkt_i,
    input  logic                        stat_mem_pkt_v_i,
    output logic                        stat_mem_pkt_yumi_o,

    input  logic                        freeze_i,

    output logic [pkt_width_lp-1:0]     pkt_o,
    output logic [1:0]                  pkt_type_o,
    output logic                        pkt_v_o,
    input  logic                        pkt_yumi_i
);

    localparam logic [1:0] type_tag_lp  = 2'd0;
    localparam logic [1:0] type_data_lp = 2'd1;
    localparam logic [1:0] type_stat_lp = 2'd2;

    logic                    v_r;
    logic [1:0]              type_r;
    logic [pkt_width_lp-1:0] pkt_r;
    logic [1:0]              last_r;

    logic                    win_v;
    logic [1:0]              win_type;
    logic [pkt_width_lp-1:0] win_pkt;
    logic                    load;

    // Arbitration: the search begins just after the last winner, so each
    // case below lists the sources in rotated priority order.
    always_comb begin
        win_v    = 1'b0;
        win_type = type_tag_lp;
        case (last_r)
            type_tag_lp: begin
                if (data_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_data_lp;
                end else if (stat_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_stat_lp;
                end else if (tag_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_tag_lp;
                end
            end
            type_data_lp: begin
                if (stat_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_stat_lp;
                end else if (tag_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_tag_lp;
                end else if (data_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_data_lp;
                end
            end
            default: begin
                if (tag_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_tag_lp;
                end else if (data_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_data_lp;
                end else if (stat_mem_pkt_v_i) begin
                    win_v = 1'b1; win_type = type_stat_lp;
                end
            end
        endcase
    end

    always_comb begin
        case (win_type)
            type_tag_lp:  win_pkt = pkt_width_lp'(tag_mem_pkt_i);
            type_data_lp: win_pkt = pkt_width_lp'(data_mem_pkt_i);
            default:      win_pkt = pkt_width_lp'(stat_mem_pkt_i);
        endcase
    end

    // A new packet may enter when the register is empty or is being drained
    // this very cycle; reset suppresses every grant.
    assign load = ~reset_i & ~freeze_i & win_v & (~v_r | pkt_yumi_i);

    assign tag_mem_pkt_yumi_o  = load & (win_type == type_tag_lp);
    assign data_mem_pkt_yumi_o = load & (win_type == type_data_lp);
    assign stat_mem_pkt_yumi_o = load & (win_type == type_stat_lp);

    // Output register stage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r    <= 1'b0;
            last_r <= type_stat_lp;
            type_r <= type_tag_lp;
            pkt_r  <= '0;
        end else if (load) begin
            v_r    <= 1'b1;
            last_r <= win_type;
            type_r <= win_type;
            pkt_r  <= win_pkt;
        end else if (pkt_yumi_i) begin
            v_r    <= 1'b0;
        end
    end

    assign pkt_o      = pkt_r;
    assign pkt_type_o = type_r;
    assign pkt_v_o    = v_r;

    // The consumer may only take a packet that is actually presented.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            yumi_without_valid: assert (v_r || !pkt_yumi_i);
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_pkt_arbiter.sv
module tb_bp_be_dcache_pkt_arbiter;

    localparam int TW = 32;
    localparam int DW = 600;
    localparam int SW = 16;
    localparam int PW = 600;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [TW-1:0] tag_pkt;
    logic          tag_v;
    logic          tag_yumi;
    logic [DW-1:0] data_pkt;
    logic          data_v;
    logic          data_yumi;
    logic [SW-1:0] stat_pkt;
    logic          stat_v;
    logic          stat_yumi;
    logic          freeze;
    logic [PW-1:0] pkt_o;
    logic [1:0]    pkt_type;
    logic          pkt_v;
    logic          pkt_yumi;
    logic [2:0]    yumis;
    logic [607:0]  rnd_wide;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign yumis = {stat_yumi, data_yumi, tag_yumi};

    bp_be_dcache_pkt_arbiter #(
        .tag_pkt_width_p (TW),
        .data_pkt_width_p(DW),
        .stat_pkt_width_p(SW)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .tag_mem_pkt_i      (tag_pkt),
        .tag_mem_pkt_v_i    (tag_v),
        .tag_mem_pkt_yumi_o (tag_yumi),
        .data_mem_pkt_i     (data_pkt),
        .data_mem_pkt_v_i   (data_v),
        .data_mem_pkt_yumi_o(data_yumi),
        .stat_mem_pkt_i     (stat_pkt),
        .stat_mem_pkt_v_i   (stat_v),
        .stat_mem_pkt_yumi_o(stat_yumi),
        .freeze_i           (freeze),
        .pkt_o              (pkt_o),
        .pkt_type_o         (pkt_type),
        .pkt_v_o            (pkt_v),
        .pkt_yumi_i         (pkt_yumi)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input logic t, input logic d, input logic s,
                         input logic f, input logic y);
        tag_v    = t;
        data_v   = d;
        stat_v   = s;
        freeze   = f;
        pkt_yumi = y;
    endtask

    task automatic rand_payloads();
        tag_pkt  = $urandom;
        stat_pkt = 16'($urandom);
        for (int i = 0; i < 19; i++) rnd_wide[i*32 +: 32] = $urandom;
        data_pkt = rnd_wide[DW-1:0];
    endtask

    function automatic logic [PW-1:0] src_payload(input int s);
        if (s == 0)      return PW'(tag_pkt);
        else if (s == 1) return PW'(data_pkt);
        else             return PW'(stat_pkt);
    endfunction

    // Leaves time at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        reset_i = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_i = 1'b0;
    endtask

    // Consume whatever is registered, with no source valid.
    task automatic drain();
        drive(0, 0, 0, 0, pkt_v);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1'b1;
        rand_payloads();
        drive(1, 1, 1, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL reset_yumi got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL reset_v got %b exp 0", pkt_v);
        else n_pass++;
        n_checks++;
        if (pkt_type !== 2'd0) $display("FAIL reset_type got %0d exp 0", pkt_type);
        else n_pass++;
        n_checks++;
        if (pkt_o !== '0) $display("FAIL reset_pkt got %h exp 0", pkt_o);
        else n_pass++;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL reset_yumi2 got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_y [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int         exp_t [4] = '{0, 1, 2, 0};
        do_reset();
        rand_payloads();
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 1, 0, c > 0);
            #1;
            n_checks++;
            if (yumis !== exp_y[c]) $display("FAIL rr_yumi c=%0d got %b exp %b", c, yumis, exp_y[c]);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (pkt_v !== 1'b1) $display("FAIL rr_v c=%0d got %b exp 1", c, pkt_v);
            else n_pass++;
            n_checks++;
            if (pkt_type !== 2'(exp_t[c])) $display("FAIL rr_type c=%0d got %0d exp %0d", c, pkt_type, exp_t[c]);
            else n_pass++;
            n_checks++;
            if (pkt_o !== src_payload(exp_t[c])) $display("FAIL rr_pkt c=%0d got %h exp %h", c, pkt_o, src_payload(exp_t[c]));
            else n_pass++;
        end
        drive(0, 0, 0, 0, 1);
        #1;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL rr_drain_yumi got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL rr_drain_v got %b exp 0", pkt_v);
        else n_pass++;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_hold();
        logic [PW-1:0] exp_p;
        do_reset();
        rand_payloads();
        data_pkt = '0;
        data_pkt[7:0] = 8'hA5;
        exp_p = '0;
        exp_p[7:0] = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 0, 0);
            #1;
            n_checks++;
            if (yumis !== ((c == 0) ? 3'b010 : 3'b000)) $display("FAIL hold_yumi c=%0d got %b", c, yumis);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (pkt_v !== 1'b1) $display("FAIL hold_v c=%0d got %b exp 1", c, pkt_v);
            else n_pass++;
            n_checks++;
            if (pkt_o !== exp_p || pkt_type !== 2'd1) $display("FAIL hold_pkt c=%0d got %h/%0d exp a5/1", c, pkt_o, pkt_type);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_freeze();
        do_reset();
        rand_payloads();
        drive(0, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b010) $display("FAIL frz_load_yumi got %b exp 010", yumis);
        else n_pass++;
        @(posedge clk); #1;
        drive(1, 0, 0, 1, 1);
        #1;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL frz_yumi got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL frz_consumed_v got %b exp 0", pkt_v);
        else n_pass++;
        drive(1, 0, 0, 1, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL frz_yumi2 got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL frz_v2 got %b exp 0", pkt_v);
        else n_pass++;
        drive(1, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b001) $display("FAIL frz_release_yumi got %b exp 001", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b1 || pkt_type !== 2'd0) $display("FAIL frz_release_out got %b/%0d exp 1/0", pkt_v, pkt_type);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_payloads();
        drive(0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b100) $display("FAIL rmid_load_yumi got %b exp 100", yumis);
        else n_pass++;
        @(posedge clk); #1;
        reset_i = 1'b1;
        drive(0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b000) $display("FAIL rmid_yumi got %b exp 000", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL rmid_v got %b exp 0", pkt_v);
        else n_pass++;
        reset_i = 1'b0;
        drive(1, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b001) $display("FAIL rmid_tag_first got %b exp 001", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_type !== 2'd0) $display("FAIL rmid_type got %0d exp 0", pkt_type);
        else n_pass++;
        drain();
        do_reset();
        drive(0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (yumis !== 3'b100) $display("FAIL rmid_stat_first got %b exp 100", yumis);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (pkt_v !== 1'b1 || pkt_type !== 2'd2) $display("FAIL rmid_stat_out got %b/%0d exp 1/2", pkt_v, pkt_type);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic            m_v;
        int              m_type;
        int              m_last;
        logic [PW-1:0]   m_pkt;
        logic [PW+1:0]   sb [$];
        logic [PW+1:0]   ent;
        int              starve [3];
        logic [2:0]      vl;
        logic [2:0]      exp_y;
        logic            f;
        logic            y;
        logic            ld;
        int              win;
        int              obs;
        do_reset();
        m_v = 1'b0; m_type = 0; m_last = 2; m_pkt = '0;
        for (int s = 0; s < 3; s++) starve[s] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rand_payloads();
            vl = 3'($urandom);
            f  = ($urandom_range(0, 7) == 0);
            y  = m_v && ($urandom_range(0, 2) != 0);
            drive(vl[0], vl[1], vl[2], f, y);
            #1;
            // reference: first valid source after the last winner, modulo 3
            win = -1;
            for (int k = 1; k <= 3; k++)
                if (win < 0 && vl[(m_last + k) % 3]) win = (m_last + k) % 3;
            ld = !f && (win >= 0) && (!m_v || y);
            exp_y = 3'b000;
            if (ld) exp_y[win] = 1'b1;
            n_checks++;
            if (yumis !== exp_y) $display("FAIL rnd_yumi cyc=%0d got %b exp %b", cyc, yumis, exp_y);
            else n_pass++;
            n_checks++;
            if ($countones(yumis) > 1) $display("FAIL rnd_onehot cyc=%0d got %b", cyc, yumis);
            else n_pass++;
            // scoreboard: retire the presented packet, then record a new grant
            if (pkt_v === 1'b1 && y) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rnd_sb_empty cyc=%0d got handshake exp none", cyc);
                else begin
                    ent = sb.pop_front();
                    if ({pkt_type, pkt_o} !== ent) $display("FAIL rnd_sb_order cyc=%0d got %0d/%h exp %0d/%h", cyc, pkt_type, pkt_o, ent[PW+1:PW], ent[PW-1:0]);
                    else n_pass++;
                end
            end
            obs = -1;
            for (int s = 2; s >= 0; s--) if (yumis[s] === 1'b1) obs = s;
            if (obs >= 0) sb.push_back({2'(obs), src_payload(obs)});
            for (int s = 0; s < 3; s++) begin
                if (!vl[s]) starve[s] = 0;
                else if (obs >= 0) begin
                    if (s == obs) starve[s] = 0;
                    else begin
                        starve[s]++;
                        n_checks++;
                        if (starve[s] > 2) $display("FAIL rnd_fair cyc=%0d src=%0d passed over %0d loads exp <=2", cyc, s, starve[s]);
                        else n_pass++;
                    end
                end
            end
            @(posedge clk); #1;
            if (ld) begin
                m_v = 1'b1; m_type = win; m_last = win; m_pkt = src_payload(win);
            end else if (y) begin
                m_v = 1'b0;
            end
            n_checks++;
            if (pkt_v !== m_v) $display("FAIL rnd_v cyc=%0d got %b exp %b", cyc, pkt_v, m_v);
            else n_pass++;
            if (m_v) begin
                n_checks++;
                if (pkt_type !== 2'(m_type) || pkt_o !== m_pkt) $display("FAIL rnd_out cyc=%0d got %0d/%h exp %0d/%h", cyc, pkt_type, pkt_o, m_type, m_pkt);
                else n_pass++;
            end
        end
        // final drain: the last presented packet must match the scoreboard head
        drive(0, 0, 0, 0, m_v);
        #1;
        if (m_v) begin
            n_checks++;
            if (sb.size() == 0) $display("FAIL rnd_drain_empty got handshake exp none");
            else begin
                ent = sb.pop_front();
                if ({pkt_type, pkt_o} !== ent) $display("FAIL rnd_drain_order got %0d exp %0d", pkt_type, ent[PW+1:PW]);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        n_checks++;
        if (sb.size() != 0) $display("FAIL rnd_leftover got %0d entries exp 0", sb.size());
        else n_pass++;
        n_checks++;
        if (pkt_v !== 1'b0) $display("FAIL rnd_end_v got %b exp 0", pkt_v);
        else n_pass++;
    endtask

    initial begin
        reset_i  = 1'b1;
        tag_pkt  = '0;
        data_pkt = '0;
        stat_pkt = '0;
        rnd_wide = '0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_round_robin();
        test_hold();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_be_dcache_pkt_arbiter.md
BP_BE_DCACHE_PKT_ARBITER -- requirements
Module: bp_be_dcache_pkt_arbiter

Interface
REQ-001 Parameter tag_pkt_width_p, default 32: width of the LCE tag_mem packet.
REQ-002 Parameter data_pkt_width_p, default 600: width of the LCE data_mem packet.
REQ-003 Parameter stat_pkt_width_p, default 16: width of the LCE stat_mem packet.
REQ-004 Localparam pkt_width_lp = max(tag, data, stat widths): width of the merged output packet.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 tag_mem_pkt_i  input  tag_pkt_width_p  tag packet payload.
REQ-009 tag_mem_pkt_v_i  input  1  tag packet valid.
REQ-010 tag_mem_pkt_yumi_o  output  1  tag packet accepted this cycle.
REQ-011 data_mem_pkt_i / data_mem_pkt_v_i / data_mem_pkt_yumi_o  in/in/out  data_pkt_width_p/1/1  data packet payload, valid, accept.
REQ-012 stat_mem_pkt_i / stat_mem_pkt_v_i / stat_mem_pkt_yumi_o  in/in/out  stat_pkt_width_p/1/1  stat packet payload, valid, accept.
REQ-013 freeze_i  input  1  when high, no new packet is granted.
REQ-014 pkt_o  output  pkt_width_lp  registered winning payload, zero-extended in the MSBs.
REQ-015 pkt_type_o  output  2  registered source: 0 = tag, 1 = data, 2 = stat; 3 is never driven.
REQ-016 pkt_v_o  output  1  pkt_o and pkt_type_o are valid.
REQ-017 pkt_yumi_i  input  1  the consumer takes pkt_o this cycle; legal only while pkt_v_o = 1.

Function
REQ-018 The block SHALL hold a one-entry output register (v_r, type_r, pkt_r) that drives pkt_v_o, pkt_type_o and pkt_o directly.
REQ-019 load = !freeze_i & (any input valid) & (!v_r | pkt_yumi_i); this gives back-to-back one packet per cycle.
REQ-020 On load, the winner's payload and type SHALL be written into the output register, and v_r is set to 1 at the next edge.
REQ-021 If pkt_yumi_i = 1 and there is no load, v_r SHALL clear to 0 at the next edge.
REQ-022 If v_r = 1, pkt_yumi_i = 0 and there is no load, the output register SHALL hold all values stable.
REQ-023 The winner SHALL be chosen round-robin: the search starts at (last_r + 1) mod 3 and takes the first valid source in order tag, data, stat.
REQ-024 last_r (2 bits) SHALL be updated to the winner's type on load only.
REQ-025 Exactly the winner's yumi SHALL assert, in the same cycle as load; the yumi outputs are combinational from the valids, last_r, v_r, pkt_yumi_i and freeze_i.
REQ-026 At most one yumi output SHALL be high in any cycle, and no yumi is high while freeze_i = 1.
REQ-027 freeze_i SHALL NOT affect an already-registered packet: it stays presented and may still be consumed.
REQ-028 The fall-through latency from input valid to pkt_v_o SHALL be 1 cycle; the block adds no bubbles when pkt_yumi_i is held high.
REQ-029 No packet SHALL be dropped or duplicated: every yumi output corresponds to exactly one later pkt_v_o and pkt_yumi_i handshake.
REQ-030 A source that is valid SHALL be granted within 3 loads (fairness bound).
REQ-031 The valid inputs need not stay stable without a yumi; the arbitration is re-evaluated every cycle.
REQ-032 pkt_yumi_i with pkt_v_o = 0 is illegal and SHALL trigger an assertion (simulation only); the RTL treats it as a no-op.

Reset
REQ-033 While reset_i = 1, all yumi outputs SHALL be 0.
REQ-034 At the first edge with reset_i = 1: v_r = 0, last_r = 2 (so tag has first priority), type_r = 0, pkt_r = 0.
REQ-035 A reset arriving while a packet is registered SHALL discard it, with pkt_v_o = 0 at the next edge; yumis already given before the reset are not replayed.

Verification
REQ-036 After reset, all three sources are valid and pkt_yumi_i is held at 1 -> the yumis assert tag, data, stat, tag over cycles 0..3 and pkt_type_o reads 0, 1, 2, 0 over cycles 1..4.
REQ-037 Data only is valid with payload 0xA5 and pkt_yumi_i = 0 for 3 cycles -> one data yumi in cycle 0, pkt_v_o = 1 and pkt_o = 0xA5 held for cycles 1..3, and no further yumi.
REQ-038 freeze_i = 1 with tag valid and a data packet registered, then pkt_yumi_i = 1 -> the data packet is consumed, pkt_v_o = 0 next cycle, and no tag yumi until freeze_i drops.
REQ-039 reset_i is pulsed while pkt_v_o = 1 and stat is valid -> pkt_v_o = 0 the cycle after reset, and the first post-reset grant goes to stat only if tag is invalid.
REQ-040 Random valids with a random pkt_yumi_i over 10k cycles -> a scoreboard checks in-order, no loss or duplication per source, at most one yumi per cycle, and a grant within 3 loads.
